// File: rtl/bit_lsr_seq_if.sv
// Request/result bundle for the sequential logical shift-right unit.
// The control side drives start/Rin/n; the shifter returns Rx/carry/busy/done.
interface bit_lsr_seq_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
);
  logic             start;
  logic [WIDTH-1:0] Rin;
  logic [SHW-1:0]   n;
  logic [WIDTH-1:0] Rx;
  logic             carry;
  logic             busy;
  logic             done;

  modport master (
    output start, Rin, n,
    input  Rx, carry, busy, done
  );

  modport slave (
    input  start, Rin, n,
    output Rx, carry, busy, done
  );
endinterface

// File: rtl/bit_lsr_seq.sv
// Multi-cycle logical shift-right: one bit position per clock, zero fill,
// reports the last bit shifted out and a single-cycle done strobe.
module bit_lsr_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic          clk,
  input  logic          reset,
  bit_lsr_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] rx_q;
  logic             carry_q;
  logic [SHW-1:0]   count;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (bus.start)
          state_next = (bus.n == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (count == SHW'(1))
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand/result register and remaining-shift counter; start is only
  // honoured in IDLE, so operand changes while busy never reach rx_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q    <= '0;
      carry_q <= 1'b0;
      count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            rx_q    <= bus.Rin;
            count   <= bus.n;
            carry_q <= 1'b0;
          end
        end
        SHIFT: begin
          rx_q    <= {1'b0, rx_q[WIDTH-1:1]};
          carry_q <= rx_q[0];
          count   <= count - SHW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.Rx    = rx_q;
    bus.carry = carry_q;
    bus.busy  = (state != IDLE);
    bus.done  = (state == DONE);
  end

endmodule

// File: tb/tb_bit_lsr_seq.sv
// Bench for bit_lsr_seq: directed table, multi-cycle corner sequences and a
// randomized run checked against a shift/latency reference model.
module tb_bit_lsr_seq;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned SHW   = 5;
  localparam int unsigned TIMEOUT = 40;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bit_lsr_seq_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  bit_lsr_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rin;
    int unsigned n;
    logic [31:0] rx;
    logic        carry;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: result is Rin >> n, carry is Rin[n-1] (0 for n=0),
  // done appears after edge E0+n, busy for edges E0..E0+n, done one cycle wide.
  task automatic run_op(input logic [31:0] rin, input int unsigned nn,
                        output logic [31:0] rx_o, output logic c_o);
    logic [31:0] exp_rx;
    logic        exp_c;
    int unsigned k;
    exp_rx = rin >> nn;
    exp_c  = 1'b0;
    if (nn != 0) exp_c = rin[nn-1];

    chk("idle_before_start", 32'(bus.busy), 32'd0);
    bus.start = 1'b1;
    bus.Rin   = rin;
    bus.n     = SHW'(nn);
    tick();
    bus.start = 1'b0;
    bus.Rin   = $urandom;
    bus.n     = SHW'($urandom);
    k = 0;
    chk("busy_at_e0", 32'(bus.busy), 32'd1);
    chk("rx_loaded", bus.Rx, rin);
    while (bus.done !== 1'b1 && k < TIMEOUT) begin
      tick();
      k++;
      chk("rx_intermediate", bus.Rx, rin >> k);
    end
    chk("latency", k, nn);
    chk("busy_with_done", 32'(bus.busy), 32'd1);
    chk("rx_result", bus.Rx, exp_rx);
    chk("carry_result", 32'(bus.carry), 32'(exp_c));
    rx_o = bus.Rx;
    c_o  = bus.carry;
    tick();
    chk("done_width", 32'(bus.done), 32'd0);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    chk("rx_hold", bus.Rx, exp_rx);
    chk("carry_hold", 32'(bus.carry), 32'(exp_c));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    tick();
    chk("reset_rx", bus.Rx, 32'd0);
    chk("reset_carry", 32'(bus.carry), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] rx_r;
    logic        c_r;
    int          done_cnt;

    vecs[0] = '{32'hE0FFC003, 12, 32'h000E0FFC, 1'b0};
    vecs[1] = '{32'd924385,    5, 32'd28887,    1'b0};
    vecs[2] = '{32'd3,         1, 32'd1,        1'b1};
    vecs[3] = '{32'h80000000, 31, 32'd1,        1'b0};
    vecs[4] = '{32'd15,        0, 32'd15,       1'b0};
    vecs[5] = '{32'hFFFFFFFF, 20, 32'h00000FFF, 1'b1};
    vecs[6] = '{32'hA5A5A5A5, 31, 32'd1,        1'b0};
    vecs[7] = '{32'h00000001,  1, 32'd0,        1'b1};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.Rin   = '0;
    bus.n     = '0;
    tick();
    tick();
    do_reset();

    // Directed table, started back-to-back at the first idle edge
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].rin, vecs[i].n, rx_r, c_r);
      chk("table_rx", rx_r, vecs[i].rx);
      chk("table_carry", 32'(c_r), 32'(vecs[i].carry));
    end

    // Starts during SHIFT and during the DONE cycle must be ignored
    bus.start = 1'b1;
    bus.Rin   = 32'hFFFFFFFF;
    bus.n     = SHW'(20);
    tick();
    done_cnt = 0;
    for (int k = 1; k <= 25; k++) begin
      bus.start = (k == 4 || k == 21);
      bus.Rin   = 32'h12345678;
      bus.n     = SHW'(3);
      tick();
      if (bus.done === 1'b1) done_cnt++;
    end
    bus.start = 1'b0;
    chk("ignored_done_count", done_cnt, 1);
    chk("ignored_rx", bus.Rx, 32'h00000FFF);
    chk("ignored_carry", 32'(bus.carry), 32'd1);
    chk("ignored_busy", 32'(bus.busy), 32'd0);

    // Reset aborts an operation in flight
    bus.start = 1'b1;
    bus.Rin   = 32'hFFFFFFFF;
    bus.n     = SHW'(10);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("abort_rx", bus.Rx, 32'd0);
    chk("abort_carry", 32'(bus.carry), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.done === 1'b1) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    run_op(32'hDEADBEEF, 7, rx_r, c_r);

    // Randomized run against the reference model
    for (int i = 0; i < 1000; i++) begin
      run_op($urandom, $urandom_range(WIDTH - 1, 0), rx_r, c_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_lsr_seq.md
Name: bit_lsr_seq

Overview:
Multi-cycle logical shift-right unit. It is the right-shift counterpart to the ALU's combinational left shifter. It accepts an operand and a shift amount on a start pulse and shifts one bit position per clock. It reports the result, the last bit shifted out, busy and a one-cycle done strobe. It sits in the ALU as the sequential LSR path; the control unit launches it and waits for done.

Parameters:
WIDTH, 32, operand/result width in bits
SHW, 5, shift-amount width; must equal log2(WIDTH)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
Rin  input  WIDTH  operand, captured on accepted start
n  input  SHW  shift amount 0..WIDTH-1, captured on accepted start
Rx  output  WIDTH  shift register / result, registered
carry  output  1  last bit shifted out of Rx[0]; 0 if n=0
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle strobe, result valid

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: on a rising edge with reset=1, state goes to IDLE and Rx=0, carry=0, busy=0, done=0, counter=0.
  - reset has priority over every other input.
  - Asserting reset mid-operation aborts the operation; no done is produced.
- State machine has three states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0: Rx<=Rin, count<=n, carry<=0.
  - If n!=0, go to SHIFT. If n==0, go to DONE and assert done at the same edge.
  - start=0: hold Rx and carry.
- SHIFT, at each edge:
  - Rx<={1'b0, Rx[WIDTH-1:1]}, carry<=Rx[0], count<=count-1.
  - If count==1, go to DONE with done<=1.
- DONE: lasts exactly one cycle with done=1. Next edge: done<=0, state IDLE.
- Latency: done is high during the cycle following edge E0+n for n>=1, and following E0 for n=0. Exactly n shifts are performed.
- Output hold:
  - Rx and carry hold their final values from DONE until the next accepted start.
  - Rx shows intermediate shift values while busy=1.
- busy: high in SHIFT and DONE.
- start while busy=1 (including the DONE cycle) is ignored. It is not queued, and Rin/n changes during busy have no effect.
- Back-to-back: a new start is accepted at the first edge on which busy=0, so the minimum spacing is n+2 edges between accepted starts.
- Zero fill on the left, always. No arithmetic mode.
- carry equals Rin[n-1] for n>=1.
- n=WIDTH-1: result is Rin[WIDTH-1] in bit 0; all others are 0.

Test Plan:
- Reset, then start with Rin=0xE0FFC003, n=12 -> busy rises at E0; done pulses after edge E0+12; Rx=0x000E0FFC, carry=0; Rx stable afterwards.
- Rin=924385, n=5 -> done after E0+5; Rx=28887, carry=0. Then Rin=3, n=1 -> Rx=1, carry=1.
- Rin=2147483648, n=31 -> done after E0+31; Rx=1, carry=0. Then Rin=15, n=0 -> done the cycle after E0, busy high one cycle, Rx=15, carry=0.
- Start with Rin=0xFFFFFFFF, n=20, and pulse start again with different Rin/n at E0+4 and during the DONE cycle -> both ignored; result Rx=0x00000FFF, carry=1, single done pulse.
- Start Rin=0xFFFFFFFF, n=10, assert reset at E0+3 -> next edge Rx=0, carry=0, busy=0, done=0, and no done ever follows. A start after reset deasserts operates normally.
- Self-checking random run: 1000 random Rin/n pairs, each started at the first idle edge -> Rx==Rin>>n, carry==(n?Rin[n-1]:0), done width 1, and latency as specified.
